// File: rtl/seven_seg_to_val.sv
// seven_seg_to_val: decodes a multiplexed seven-segment bus (segs = abcdefg,
// one-hot digit_sel) back into an 8-bit binary value. Each digit is accepted
// after STABLE_CYCLES identical samples; a complete frame is accumulated as
// decimal and emitted with a one-cycle valid pulse.
// Optional build macro: SEG_INVERT_EN -- treat segs as active-low
// (common-anode bus) by inverting it ahead of the filter and decoder.
module seven_seg_to_val #(
  parameter int NUM_DIGITS    = 3,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            segs,
  input  logic [NUM_DIGITS-1:0] digit_sel,
  output logic [7:0]            value,
  output logic                  valid,
  output logic                  err,
  output logic                  ovf
);

  localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(STABLE_CYCLES - 2);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    COLLECT,
    ACCUM,
    DONE
  } state_t;

  state_t state, state_next;

  logic [6:0]                    seg_in;
  logic [NUM_DIGITS+6:0]         sample;
  logic [NUM_DIGITS+6:0]         prev;
  logic [CNT_W-1:0]              cnt;
  logic                          sel_ok;
  logic                          same;
  logic                          capture;
  logic [3:0]                    dec_digit;
  logic                          dec_bad;
  logic [NUM_DIGITS-1:0]         mask;
  logic [3:0]                    slot_digit [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]         slot_bad;
  logic [9:0]                    acc;
  logic [IDX_W-1:0]              idx;
  logic                          cap_en;
  logic                          frame_done;
  logic                          acc_step;
  logic                          emit;

`ifdef SEG_INVERT_EN
  assign seg_in = ~segs;
`else
  assign seg_in = segs;
`endif

  assign sample  = {digit_sel, seg_in};
  assign same    = (sample == prev);
  assign sel_ok  = $onehot(digit_sel);
  assign capture = sel_ok && same && (cnt == CNT_ARM);

  // Pattern decoder: blank reads as 0 so leading blanks are harmless
  always_comb begin
    dec_digit = '0;
    dec_bad   = 1'b0;
    case (seg_in)
      7'b1111110: dec_digit = 4'd0;
      7'b0000000: dec_digit = 4'd0;
      7'b0110000: dec_digit = 4'd1;
      7'b1101101: dec_digit = 4'd2;
      7'b1111001: dec_digit = 4'd3;
      7'b0110011: dec_digit = 4'd4;
      7'b1011011: dec_digit = 4'd5;
      7'b1011111: dec_digit = 4'd6;
      7'b1110000: dec_digit = 4'd7;
      7'b1111111: dec_digit = 4'd8;
      7'b1111011: dec_digit = 4'd9;
      default:    dec_bad   = 1'b1;
    endcase
  end

  // Stability filter: count identical samples, saturating so a held digit
  // produces exactly one capture
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= '0;
      cnt  <= '0;
    end else begin
      prev <= sample;
      if (!sel_ok || !same) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (frame_done) state_next = ACCUM;
      ACCUM:   if (idx == '0) state_next = DONE;
      DONE:    state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  // FSM output decode
  always_comb begin
    cap_en     = (state == COLLECT) && capture;
    frame_done = cap_en && ((mask | digit_sel) == '1);
    acc_step   = (state == ACCUM);
    emit       = (state == DONE);
  end

  // Digit slots and capture mask
  always_ff @(posedge clk) begin
    if (rst) begin
      mask     <= '0;
      slot_bad <= '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        slot_digit[i] <= '0;
      end
    end else begin
      if (frame_done) begin
        mask <= '0;
      end else if (cap_en) begin
        mask <= mask | digit_sel;
      end
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (cap_en && digit_sel[i]) begin
          slot_digit[i] <= dec_digit;
          slot_bad[i]   <= dec_bad;
        end
      end
    end
  end

  // Decimal accumulator, most significant slot first
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      idx <= '0;
    end else if (frame_done) begin
      acc <= '0;
      idx <= IDX_TOP;
    end else if (acc_step) begin
      acc <= acc * 10'd10 + {6'b0, slot_digit[idx]};
      idx <= idx - 1'b1;
    end
  end

  // Result registers: updated only when a frame completes, held otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      valid <= emit;
      if (emit) begin
        if (|slot_bad) begin
          value <= '0;
          err   <= 1'b1;
          ovf   <= 1'b0;
        end else if (acc > 10'd255) begin
          value <= '1;
          err   <= 1'b0;
          ovf   <= 1'b1;
        end else begin
          value <= acc[7:0];
          err   <= 1'b0;
          ovf   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_to_val.sv
// Directed testbench for seven_seg_to_val (default parameters). Build with
// SEG_INVERT_EN defined to exercise the active-low bus; stimulus patterns
// are written active-high and inverted by enc() in that build.
module tb_seven_seg_to_val;

  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S1 = 7'b0110000;
  localparam logic [6:0] S2 = 7'b1101101;
  localparam logic [6:0] S3 = 7'b1111001;
  localparam logic [6:0] S4 = 7'b0110011;
  localparam logic [6:0] S5 = 7'b1011011;
  localparam logic [6:0] S8 = 7'b1111111;
  localparam logic [6:0] S9 = 7'b1111011;
  localparam logic [6:0] SB = 7'b0000000;
  localparam logic [6:0] SX = 7'b1000000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] segs = '0;
  logic [2:0] digit_sel = '0;
  logic [7:0] value;
  logic       valid;
  logic       err;
  logic       ovf;

  int n_checks = 0;
  int n_fail = 0;
  int edge_cnt = 0;
  int pulses = 0;
  int pulse_edge = 0;
  int e0 = 0;
  int base = 0;

  seven_seg_to_val #(
    .NUM_DIGITS   (3),
    .STABLE_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .segs     (segs),
    .digit_sel(digit_sel),
    .value    (value),
    .valid    (valid),
    .err      (err),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt++;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      pulses++;
      pulse_edge = edge_cnt;
    end
  end

  function automatic logic [6:0] enc(input logic [6:0] p);
`ifdef SEG_INVERT_EN
    return ~p;
`else
    return p;
`endif
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one digit for n rising edges; e0 marks the last of them
  task automatic drive(input logic [2:0] sel, input logic [6:0] pat, input int n);
    @(negedge clk);
    digit_sel = sel;
    segs = enc(pat);
    repeat (n) @(posedge clk);
    #1;
    e0 = edge_cnt;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_frame(input string tag, input int b, input int ev,
                              input int ee, input int eo);
    for (int k = 0; k < 16 && pulses == b; k++) @(negedge clk);
    check({tag, "_valid"}, pulses, b + 1);
    check({tag, "_latency"}, pulse_edge - e0, 4);
    check({tag, "_value"}, 32'(value), ev);
    check({tag, "_err"}, 32'(err), ee);
    check({tag, "_ovf"}, 32'(ovf), eo);
    idle(4);
    check({tag, "_single"}, pulses, b + 1);
  endtask

  task automatic run_frame(input string tag, input logic [6:0] p2, input logic [6:0] p1,
                           input logic [6:0] p0, input int ev, input int ee, input int eo);
    int b;
    b = pulses;
    drive(3'b100, p2, 4);
    drive(3'b010, p1, 4);
    drive(3'b001, p0, 4);
    expect_frame(tag, b, ev, ee, eo);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset
    rst = 1'b1;
    digit_sel = '0;
    segs = enc(SB);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_value", 32'(value), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_err", 32'(err), 0);
    check("rst_ovf", 32'(ovf), 0);
    rst = 1'b0;
    segs = '0;
    idle(12);
    check("rst_idle_pulses", pulses, 0);

    // Nominal and overflow frames
    run_frame("nom", S1, S2, S8, 128, 0, 0);
    run_frame("ovf", S9, S9, S9, 255, 0, 1);
    run_frame("blank", SB, S4, S2, 42, 0, 0);

    // Glitch: d0 held only 3 edges is ignored
    base = pulses;
    drive(3'b100, S1, 4);
    drive(3'b010, S0, 4);
    drive(3'b001, S3, 3);
    drive(3'b010, S0, 4);
    idle(10);
    check("glitch_no_valid", pulses, base);
    drive(3'b001, S3, 4);
    expect_frame("glitch", base, 103, 0, 0);

    // Invalid pattern, then non-one-hot strobe must not capture
    run_frame("inv", S0, SX, S5, 0, 1, 0);
    base = pulses;
    drive(3'b011, S0, 10);
    check("nonhot_no_valid", pulses, base);
    drive(3'b100, S1, 4);
    idle(10);
    check("nonhot_no_capture", pulses, base);
    drive(3'b010, S2, 4);
    drive(3'b001, S5, 4);
    expect_frame("after_nonhot", base, 125, 0, 0);

    // Reset one edge after the completing capture
    base = pulses;
    drive(3'b100, S3, 4);
    drive(3'b010, S3, 4);
    drive(3'b001, S3, 4);
    rst = 1'b1;
    digit_sel = '0;
    segs = enc(SB);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("accrst_value", 32'(value), 0);
    idle(12);
    check("accrst_no_valid", pulses, base);
    run_frame("max", S2, S5, S5, 255, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_to_val.md
# seven_seg_to_val

Decodes a multiplexed seven-segment display bus back into a binary value, the inverse of the greenhouse FPGA's value-to-segment encoding. It samples segment lines plus a one-hot digit strobe and accepts each digit only after it has been stable for a programmable number of cycles. Once every digit of a frame is captured, it assembles the decimal digits into an 8-bit value and emits it with a one-cycle valid pulse. It serves as a loopback checker and display-bus monitor alongside the display drivers.

## Interface
- NUM_DIGITS, 3: digits per frame; bit i of digit_sel is decimal digit i, where i=0 is the least significant.
- STABLE_CYCLES, 4: consecutive identical samples needed to accept a digit (minimum 2).
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- segs  input  7  segment lines; bit6=a … bit0=g; active-high unless SEG_INVERT_EN is defined.
- digit_sel  input  NUM_DIGITS  one-hot digit strobe, active-high.
- value  output  8  decoded frame value.
- valid  output  1  one-cycle pulse; value/err/ovf are new.
- err  output  1  frame contained an undecodable pattern.
- ovf  output  1  decimal frame value exceeded 255.

## Operation
- Decode table, patterns in abcdefg order:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - blank=0000000 decodes as 0, supporting leading blanks.
  - Any other pattern is invalid.
- Stability filter:
  - Registers the previous {digit_sel, segs} sample.
  - Counter cnt resets to 0 when the current sample differs from the previous one; otherwise it increments, saturating at STABLE_CYCLES-1.
  - Capture occurs at the edge where cnt goes from STABLE_CYCLES-2 to STABLE_CYCLES-1, exactly once per stable run.
  - If digit_sel is zero or not one-hot, cnt is forced to 0 and no capture occurs.
- Capture:
  - Writes a 4-bit digit and an invalid flag into slot[i] and sets mask[i].
  - Recapturing the same digit overwrites its slot.
- State machine:
  - COLLECT: capture enabled. At the capture edge that makes mask all ones, go to ACCUM, set acc=0, idx=NUM_DIGITS-1, and clear mask.
  - ACCUM: at each edge, acc <= acc*10 + slot[idx] and idx decrements. After NUM_DIGITS edges, go to DONE. Captures are discarded in this state.
  - DONE: register the outputs, pulse valid, return to COLLECT. Captures are discarded in this state.
- Arithmetic: acc is 10 bits wide (max 999).
- Output rules:
  - If any slot is invalid: value=0, err=1, ovf=0.
  - Else if acc>255: value=8'hFF, ovf=1.
  - Else: value=acc[7:0], err=0, ovf=0.
- value, err and ovf hold between frames. valid is high only for the DONE cycle.

## Timing
- Reset values:
  - Outputs: value=0, valid=0, err=0, ovf=0.
  - Internal: state=COLLECT, mask=0, cnt=0, previous sample=0, slots=0.
- A pattern must be present at STABLE_CYCLES consecutive rising edges; it is captured on the last of them (edge E0).
- When E0 completes a frame, valid is high during the cycle following edge E0+NUM_DIGITS+1. For the default parameters, that is 4 edges after E0.
- Frame repeat: a new frame can begin collecting in the cycle valid is high.
- Reset asserted mid-ACCUM or mid-DONE: return to the reset state. No valid is emitted for that frame.
- Simultaneous digit_sel and segs change: treated as one sample change, so cnt restarts at 0.

## Configuration
- SEG_INVERT_EN:
  - Defined: segs is inverted at the input before the filter and decode. This supports common-anode, active-low buses, where blank=1111111.
  - Undefined: segs is used as-is (active-high).

## Test plan
All tests use defaults and no macro unless stated.
- Reset check: assert rst for 2 cycles -> value=0, valid=0, err=0, ovf=0; no valid afterwards while segs=0 and digit_sel=0.
- Nominal frame: drive d2=0110000, d1=1101101, d0=1111111, 4 cycles each -> exactly one valid pulse, 4 cycles after the d0 capture edge, with value=128, err=0, ovf=0.
- Overflow: 9,9,9 -> value=8'hFF, ovf=1, err=0. Then blank,4,2 -> value=42, ovf=0.
- Glitch rejection: hold d0=1111001 for only 3 cycles between valid digits -> that digit is not captured; no valid until d0 is held 4 cycles.
- Invalid pattern: d1=1000000 within a frame -> valid with err=1, value=0. A non-one-hot digit_sel=3'b011 held 10 cycles -> no capture.
- Reset during ACCUM: assert rst for 1 cycle one edge after the completing capture -> no valid; the next full frame decodes correctly.
- Active-low build: with SEG_INVERT_EN defined, repeat the nominal frame using inverted patterns -> value=128.
